// File: rtl/irda_defines.sv
// Shared IrDA FIR constants: 4PPM chip patterns, chip counter width, preamble symbols.
// Chip [3] of every 4-chip symbol is the first on air.
package irda_defines;

  localparam int PPM4_CHIP_CNT_W = 2;

  localparam logic [3:0] PPM4_SYM_00 = 4'b1000;
  localparam logic [3:0] PPM4_SYM_01 = 4'b0100;
  localparam logic [3:0] PPM4_SYM_10 = 4'b0010;
  localparam logic [3:0] PPM4_SYM_11 = 4'b0001;

  // Preamble symbol sequence for the framer, first symbol in the top nibble
  localparam logic [15:0] FIR_PREAMBLE_SEQ = 16'b1000_0000_1010_1000;

endpackage

// File: rtl/irda_fir_4ppm_sym_map.sv
// Dibit to 4PPM chip pattern lookup, purely combinational.
// dibit is {second bit, first bit} as received LSB first from the framer.
module irda_fir_4ppm_sym_map
  import irda_defines::*;
(
  input  logic [1:0] dibit,
  output logic [3:0] chips
);

  always_comb begin
    chips = PPM4_SYM_00;
    case (dibit)
      2'b00:   chips = PPM4_SYM_00;
      2'b01:   chips = PPM4_SYM_01;
      2'b10:   chips = PPM4_SYM_10;
      default: chips = PPM4_SYM_11;
    endcase
  end

endmodule

// File: rtl/irda_fir_4ppm_encoder.sv
// FIR 4 Mb/s transmit 4PPM encoder: two framer bits per symbol, one chip per 8 MHz strobe.
// Bits gathered during symbol N go out as symbol N+1; raw path lets the framer send flag symbols.
module irda_fir_4ppm_encoder
  import irda_defines::*;
(
  input  logic       clk,
  input  logic       wb_rst_i,
  input  logic       fir_tx8_enable,
  input  logic       ppme_enable,
  input  logic       ppme_restart,
  input  logic       ppme_i,
  input  logic       ppme_raw_sel,
  input  logic [3:0] ppme_raw_sym,
  output logic       ppme_bit_req,
  output logic       ppme_sym_start,
  output logic       fir_tx_o
);

  logic [PPM4_CHIP_CNT_W-1:0] chip_cnt;
  logic                       bit0;
  logic [3:0]                 next_sym;
  logic [3:0]                 shift;
  logic [3:0]                 mapped_sym;

  irda_fir_4ppm_sym_map u_sym_map (
    .dibit (({ppme_i, bit0})),
    .chips (mapped_sym)
  );

  // Odd chip slots are where the framer's two data bits are taken
  assign ppme_bit_req = fir_tx8_enable & ppme_enable & ~ppme_restart &
                        chip_cnt[0] & ~ppme_raw_sel;

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      chip_cnt       <= '0;
      bit0           <= 1'b0;
      next_sym       <= 4'b0000;
      shift          <= 4'b0000;
      fir_tx_o       <= 1'b0;
      ppme_sym_start <= 1'b0;
    end else if (ppme_restart || !ppme_enable) begin
      // Clearing next_sym makes the first symbol after (re)start a dark fill symbol
      chip_cnt       <= '0;
      next_sym       <= 4'b0000;
      shift          <= 4'b0000;
      fir_tx_o       <= 1'b0;
      ppme_sym_start <= 1'b0;
    end else if (fir_tx8_enable) begin
      chip_cnt       <= chip_cnt + 1'b1;
      ppme_sym_start <= (chip_cnt == '0);
      case (chip_cnt)
        2'd0: begin
          shift    <= next_sym;
          fir_tx_o <= next_sym[3];
        end
        2'd1: begin
          fir_tx_o <= shift[2];
          if (!ppme_raw_sel) bit0 <= ppme_i;
        end
        2'd2: begin
          fir_tx_o <= shift[1];
        end
        default: begin
          fir_tx_o <= shift[0];
          next_sym <= ppme_raw_sel ? ppme_raw_sym : mapped_sym;
        end
      endcase
    end else begin
      ppme_sym_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_irda_fir_4ppm_encoder.sv
// Directed bench for the FIR 4PPM encoder: symbol table plus hand-written restart/enable/reset sequences.
module tb_irda_fir_4ppm_encoder;

  logic       clk = 1'b0;
  logic       wb_rst_i;
  logic       fir_tx8_enable;
  logic       ppme_enable;
  logic       ppme_restart;
  logic       ppme_i;
  logic       ppme_raw_sel;
  logic [3:0] ppme_raw_sym;
  logic       ppme_bit_req;
  logic       ppme_sym_start;
  logic       fir_tx_o;

  int checks   = 0;
  int failures = 0;
  int req_cnt  = 0;

  irda_fir_4ppm_encoder dut (
    .clk            (clk),
    .wb_rst_i       (wb_rst_i),
    .fir_tx8_enable (fir_tx8_enable),
    .ppme_enable    (ppme_enable),
    .ppme_restart   (ppme_restart),
    .ppme_i         (ppme_i),
    .ppme_raw_sel   (ppme_raw_sel),
    .ppme_raw_sym   (ppme_raw_sym),
    .ppme_bit_req   (ppme_bit_req),
    .ppme_sym_start (ppme_sym_start),
    .fir_tx_o       (fir_tx_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       b0;
    logic       b1;
    logic       raw_sel;
    logic [3:0] raw_sym;
    logic [3:0] exp_chips;
  } sym_vec_t;

  sym_vec_t vecs[$];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // One full symbol: four strobes, each followed by an idle clk; starts and ends at a negedge
  task automatic do_sym(input logic b0, input logic b1, input logic rs,
                        input logic [3:0] rsym, output logic [3:0] chips);
    for (int k = 0; k < 4; k++) begin
      fir_tx8_enable = 1'b1;
      ppme_raw_sel   = rs;
      ppme_raw_sym   = rsym;
      ppme_i         = (k == 1) ? b0 : ((k == 3) ? b1 : 1'b0);
      #1;
      chk("bit_req", {3'b0, ppme_bit_req}, {3'b0, (k % 2 == 1) && !rs});
      if (ppme_bit_req) req_cnt++;
      @(posedge clk); @(negedge clk);
      chips[3-k] = fir_tx_o;
      chk("sym_start", {3'b0, ppme_sym_start}, {3'b0, k == 0});
      fir_tx8_enable = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("sym_start_idle", {3'b0, ppme_sym_start}, 4'b0);
      chk("tx_hold", {3'b0, fir_tx_o}, {3'b0, chips[3-k]});
    end
  endtask

  task automatic run_rows(input int first, input int last);
    logic [3:0] chips;
    for (int r = first; r <= last; r++) begin
      do_sym(vecs[r].b0, vecs[r].b1, vecs[r].raw_sel, vecs[r].raw_sym, chips);
      chk($sformatf("chips_row%0d", r), chips, vecs[r].exp_chips);
    end
  endtask

  task automatic one_strobe(input logic i, input logic exp_tx, input logic exp_start);
    fir_tx8_enable = 1'b1;
    ppme_raw_sel   = 1'b0;
    ppme_i         = i;
    @(posedge clk); @(negedge clk);
    chk("partial_tx", {3'b0, fir_tx_o}, {3'b0, exp_tx});
    chk("partial_start", {3'b0, ppme_sym_start}, {3'b0, exp_start});
    fir_tx8_enable = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  // Independent receive-side view: one-hot position gives the dibit
  function automatic logic [2:0] rx_decode(input logic [3:0] chips);
    logic [1:0] d;
    int ones;
    d = 2'b00;
    ones = 0;
    for (int p = 0; p < 4; p++) begin
      if (chips[p]) begin
        ones++;
        d = 2'(3 - p);
      end
    end
    return {ones != 1, d};
  endfunction

  initial begin
    logic [3:0] chips;
    logic [2:0] dec;
    logic [1:0] prev_bits;
    logic       rb0, rb1;

    // rows 0-4: data walk; 5-8: raw path; 9-10: after restart; 11-12: after re-enable
    vecs.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0100});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 4'b0000, 4'b0010});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 4'b0000, 4'b0100});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 4'b1010, 4'b0000});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 4'b0000, 4'b1010});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0010});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0100});

    wb_rst_i = 1'b1; fir_tx8_enable = 1'b0; ppme_enable = 1'b0; ppme_restart = 1'b0;
    ppme_i = 1'b0; ppme_raw_sel = 1'b0; ppme_raw_sym = 4'b0000;
    @(negedge clk); @(negedge clk);
    chk("rst_tx", {3'b0, fir_tx_o}, 4'b0);
    chk("rst_start", {3'b0, ppme_sym_start}, 4'b0);
    chk("rst_req", {3'b0, ppme_bit_req}, 4'b0);
    wb_rst_i = 1'b0;
    ppme_enable = 1'b1;
    @(negedge clk);

    // data path: fill then 1000 0100 0010 0001
    run_rows(0, 4);

    // raw path after a fresh enable
    ppme_enable = 1'b0;
    @(negedge clk);
    ppme_enable = 1'b1;
    req_cnt = 0;
    run_rows(5, 7);
    chk("raw_req_count", 4'(req_cnt), 4'd2);
    run_rows(8, 8);

    // restart at chip_cnt=2 of a 0001 symbol
    one_strobe(1'b0, 1'b0, 1'b1);
    one_strobe(1'b1, 1'b0, 1'b0);
    ppme_restart = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("restart_tx", {3'b0, fir_tx_o}, 4'b0);
    ppme_restart = 1'b0;
    run_rows(9, 10);

    // drop enable while a lit chip is out, strobes keep running
    one_strobe(1'b0, 1'b1, 1'b1);
    ppme_enable = 1'b0;
    for (int c = 0; c < 6; c++) begin
      fir_tx8_enable = 1'b1;
      ppme_i = 1'b1;
      #1;
      chk("dis_req", {3'b0, ppme_bit_req}, 4'b0);
      @(posedge clk); @(negedge clk);
      chk("dis_tx", {3'b0, fir_tx_o}, 4'b0);
      chk("dis_start", {3'b0, ppme_sym_start}, 4'b0);
    end
    fir_tx8_enable = 1'b0;
    ppme_enable = 1'b1;
    run_rows(11, 12);

    // strobe coincident with restart is ignored, then random traffic through the decoder
    fir_tx8_enable = 1'b1; ppme_restart = 1'b1; ppme_i = 1'b1;
    #1;
    chk("rs_strobe_req", {3'b0, ppme_bit_req}, 4'b0);
    @(posedge clk); @(negedge clk);
    chk("rs_strobe_tx", {3'b0, fir_tx_o}, 4'b0);
    chk("rs_strobe_start", {3'b0, ppme_sym_start}, 4'b0);
    fir_tx8_enable = 1'b0; ppme_restart = 1'b0;
    @(negedge clk);
    prev_bits = 2'b00;
    for (int n = 0; n <= 200; n++) begin
      rb0 = 1'($urandom_range(1));
      rb1 = 1'($urandom_range(1));
      do_sym(rb0, rb1, 1'b0, 4'b0000, chips);
      if (n == 0) begin
        chk("rand_fill", chips, 4'b0000);
      end else begin
        dec = rx_decode(chips);
        chk("rand_bad_chip", {3'b0, dec[2]}, 4'b0);
        chk("rand_bits", {2'b0, dec[1:0]}, {2'b0, prev_bits});
      end
      prev_bits = {rb1, rb0};
    end

    // async reset while a lit chip is on the pin
    do_sym(1'b0, 1'b0, 1'b0, 4'b0000, chips);
    dec = rx_decode(chips);
    chk("pre_rst_bits", {2'b0, dec[1:0]}, {2'b0, prev_bits});
    one_strobe(1'b0, 1'b1, 1'b1);
    #2;
    wb_rst_i = 1'b1;
    #1;
    chk("arst_tx", {3'b0, fir_tx_o}, 4'b0);
    chk("arst_start", {3'b0, ppme_sym_start}, 4'b0);
    @(negedge clk);
    wb_rst_i = 1'b0;
    do_sym(1'b1, 1'b1, 1'b0, 4'b0000, chips);
    chk("post_rst_fill", chips, 4'b0000);
    do_sym(1'b0, 1'b0, 1'b0, 4'b0000, chips);
    chk("post_rst_sym", chips, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
